mdu_issue: RTL and testbench

MDU_ISSUE -- requirements
Module: mdu_issue

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_special_case.sv | 31 +++
 rtl/mdu_issue.sv | 149 ++++++++++++++
 tb/tb_mdu_issue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU issue definitions: M-extension op encodings, issue FSM states, latched request.
// No logic of its own; imported by mdu_issue and mdu_special_case.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } mdu_state_e;

  typedef struct packed {
    mdu_op_e     op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
  } mdu_req_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Division-class ops share the top encoding bit; remainder ops also set bit 1.
  function automatic logic is_div_class(mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(mdu_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_special_case.sv
// Combinational detector for divide-by-zero and signed-overflow results; zero latency.
// No handshake: result is valid whenever inputs are, the issuer decides when to use it.
module mdu_special_case
  import mdu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        hit,
  output logic [31:0] result
);

  mdu_op_e op;

  assign op = mdu_op_e'(funct3);

  always_comb begin
    hit    = 1'b0;
    result = '0;
    if (is_div_class(op)) begin
      if (rs2 == '0) begin
        hit    = 1'b1;
        result = is_rem(op) ? rs1 : ALL_ONES;
      end else if ((op == OP_DIV || op == OP_REM) && rs1 == INT_MIN && rs2 == ALL_ONES) begin
        hit    = 1'b1;
        result = is_rem(op) ? 32'h0 : INT_MIN;
      end
    end
  end

endmodule

// File: rtl/mdu_issue.sv
// Issues one M-extension op to an iterative MDU and writes back its result; WB >= 3 cycles after accept.
// Holds the pipeline via stall while busy; flush squashes, timeout aborts. MDU_SPECIAL_CASE_EN adds 1-cycle special results.
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_is_mdu,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        mdu_start,
  output logic [2:0]  mdu_operation,
  output logic [31:0] mdu_x,
  output logic [31:0] mdu_y,
  input  logic        mdu_done,
  input  logic [31:0] mdu_result,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  mdu_req_t         req_q;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, err_d;
  logic             accept, load_req, cnt_clr, cnt_run, cnt_last;

  assign accept   = in_valid & in_is_mdu & ~flush;
  assign cnt_run  = (state_q == WAIT) || (state_q == DRAIN);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_clr  = (state_d != state_q) && ((state_d == WAIT) || (state_d == DRAIN));

`ifdef MDU_SPECIAL_CASE_EN
  logic        sc_hit;
  logic [31:0] sc_result;

  mdu_special_case u_special_case (
    .funct3 (in_funct3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .hit    (sc_hit),
    .result (sc_result)
  );
`endif

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    load_req  = 1'b0;
    err_d     = 1'b0;
    stall     = 1'b0;
    mdu_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          load_req = 1'b1;
          state_d  = ISSUE;
`ifdef MDU_SPECIAL_CASE_EN
          if (sc_hit) begin
            state_d   = WB;
            wb_data_d = sc_result;
          end
`endif
        end
      end
      ISSUE: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          mdu_start = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A done coinciding with flush has nothing left to drain, so drop it straight away.
        if (flush) begin
          state_d = mdu_done ? IDLE : DRAIN;
        end else if (mdu_done) begin
          wb_data_d = mdu_result;
          state_d   = WB;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mdu_done) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      if (load_req) begin
        req_q <= '{op: mdu_op_e'(in_funct3), x: in_rs1, y: in_rs2, rd: in_rd};
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_run) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Operands stay on the MDU bus until the next accept so the MDU can select by operation late.
  assign mdu_operation = req_q.op;
  assign mdu_x         = req_q.x;
  assign mdu_y         = req_q.y;
  assign wb_valid      = (state_q == WB) && (req_q.rd != 5'd0);
  assign wb_rd         = req_q.rd;
  assign wb_data       = wb_data_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_mdu_issue.sv
// Scoreboarded bench for mdu_issue: random and directed ops against an arithmetic MDU model.
// A responder stub plays the MDU; a monitor pops expected starts, writebacks and timeouts.
module tb_mdu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_is_mdu, flush;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        mdu_start, mdu_done;
  logic [2:0]  mdu_operation;
  logic [31:0] mdu_x, mdu_y, mdu_result;
  logic        stall, wb_valid, err_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mdu_issue #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_is_mdu(in_is_mdu), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .mdu_start(mdu_start), .mdu_operation(mdu_operation), .mdu_x(mdu_x), .mdu_y(mdu_y),
    .mdu_done(mdu_done), .mdu_result(mdu_result),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_timeout(err_timeout)
  );

  typedef struct { logic [2:0] op; logic [31:0] x; logic [31:0] y; int c; } start_exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] d; int c; } wb_exp_t;

  start_exp_t st_q[$];
  wb_exp_t    wb_q[$];
  int         to_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_cyc = 0;
  int mdu_lat = 1;
  int spur_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics written as plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit en;
`ifdef MDU_SPECIAL_CASE_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && ((op >= 3'd4 && b == 0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // MDU stub: answers each start after mdu_lat cycles (0 = never), or fires a spurious done on request.
  int          done_cnt = 0;
  int          spur_done = 0;
  logic [31:0] pending = 0;
  initial begin
    mdu_done = 1'b0;
    mdu_result = '0;
    forever begin
      @(negedge clk);
      mdu_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          mdu_done = 1'b1;
          mdu_result = pending;
        end
      end else if (spur_done != spur_req) begin
        spur_done = spur_req;
        mdu_done = 1'b1;
        mdu_result = $urandom;
      end
      #2;
      if (mdu_start && done_cnt == 0) begin
        pending = ref_mdu(mdu_operation, mdu_x, mdu_y);
        done_cnt = mdu_lat;
      end
    end
  end

  initial begin
    start_exp_t se;
    wb_exp_t    we;
    int         te;
    forever begin
      @(negedge clk);
      #2;
      if (mdu_start) begin
        if (st_q.size() == 0) chk("start_unexpected", 32'(mdu_start), 32'd0);
        else begin
          se = st_q.pop_front();
          chk("start_op", 32'(mdu_operation), 32'(se.op));
          chk("start_x", mdu_x, se.x);
          chk("start_y", mdu_y, se.y);
          chk("start_cycle", 32'(cyc), 32'(se.c));
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'd0);
        else begin
          we = wb_q.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(we.rd));
          chk("wb_data", wb_data, we.d);
          chk("wb_cycle", 32'(cyc), 32'(we.c));
        end
      end
      if (err_timeout) begin
        if (to_q.size() == 0) chk("timeout_unexpected", 32'(err_timeout), 32'd0);
        else begin
          te = to_q.pop_front();
          chk("timeout_cycle", 32'(cyc), 32'(te));
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, 32'(mdu_start), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    chk({tag, "_op"}, 32'(mdu_operation), 32'd0);
    chk({tag, "_x"}, mdu_x, 32'd0);
    chk({tag, "_y"}, mdu_y, 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // Presents an op and holds it until stall shows the DUT has taken it (cycle returned in acc).
  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acc, output bit ok);
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_is_mdu = 1'b1; in_funct3 = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    ok = 1'b0; acc = 0; k = 0;
    while (!ok && k < 400) begin
      #1;
      chk("stall_accept", 32'(stall), 32'(cyc >= ready_cyc));
      if (stall) begin
        ok = 1'b1;
        acc = cyc;
      end else begin
        k++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("accept_bound", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  // lat: MDU latency after start (0 = never answers); f: flush this many cycles after accept (0 = none).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int f);
    int          acc, e;
    bit          ok;
    logic [31:0] r;
    mdu_lat = lat;
    present(op, a, b, rd, acc, ok);
    if (!ok) return;
    r = ref_mdu(op, a, b);
    if (is_special(op, a, b)) begin
      if (rd != 0) wb_q.push_back('{rd, r, acc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("stall_special_wb", 32'(stall), 32'd0);
      ready_cyc = acc + 2;
      return;
    end
    if (f == 1) begin
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      ready_cyc = acc + 2;
      return;
    end
    st_q.push_back('{op, a, b, acc + 1});
    if (f >= 2) begin
      for (int c = 1; c < f; c++) begin
        @(negedge clk);
        #1 chk("stall_busy", 32'(stall), 32'd1);
      end
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      ready_cyc = acc + 2 + lat;
      return;
    end
    if (lat == 0) begin
      e = acc + 257;
      to_q.push_back(e);
      ready_cyc = e;
    end else begin
      e = acc + 2 + lat;
      if (rd != 0) wb_q.push_back('{rd, r, e});
      ready_cyc = e + 1;
    end
    for (int c = acc + 1; c <= e; c++) begin
      @(negedge clk);
      if (c == e) in_valid = 1'b0;
      #1 chk("stall_busy", 32'(stall), 32'(c < e));
    end
  endtask

  task automatic reset_mid();
    int acc;
    bit ok;
    mdu_lat = 40;
    present(3'd0, 32'h1234, 32'h55, 5'd9, acc, ok);
    if (!ok) return;
    st_q.push_back('{3'd0, 32'h1234, 32'h55, acc + 1});
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset("rst_mid");
    rst_n = 1'b1;
    ready_cyc = cyc;
    repeat (50) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_chk);
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          lat, f;
    rst_n = 1'b0; in_valid = 1'b0; in_is_mdu = 1'b0; flush = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (3) @(negedge clk);
    #1 check_reset("rst_init");
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 4, 0);
    spur_req++;
    repeat (4) @(negedge clk);
    run_op(3'd5, 32'd100, 32'd7, 5'd3, 6, 3);
    run_op(3'd0, 32'd2, 32'd3, 5'd4, 2, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 3, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 3, 0);
    run_op(3'd7, 32'd9, 32'd0, 5'd8, 2, 0);
    run_op(3'd6, 32'd5, 32'd3, 5'd10, 0, 0);
    reset_mid();
    run_op(3'd4, 32'd50, 32'd5, 5'd6, 3, 1);

    // Non-MDU ops and flushed MDU ops must not be taken.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_is_mdu = (i % 2 == 1); flush = (i % 2 == 1);
      in_funct3 = 3'd1; in_rs1 = 32'd11; in_rs2 = 32'd13; in_rd = 5'd2;
      #1 chk("stall_not_taken", 32'(stall), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lat = $urandom_range(1, 8);
      f   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
      run_op(op, a, b, rd, lat, f);
    end

    repeat (12) @(negedge clk);
    chk("start_queue_empty", 32'(st_q.size()), 32'd0);
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    chk("timeout_queue_empty", 32'(to_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
